// File: rtl/light_hash_stream.sv
// Streaming character hash: absorbs a valid/ready byte stream and compresses it with
// AES S-box rounds into a DIGEST_BYTES-byte digest, framed by terminator beats.
module light_hash_stream #(
  parameter int unsigned                  DIGEST_BYTES = 8,
  parameter int unsigned                  ROUNDS       = 4,
  parameter logic [8*DIGEST_BYTES-1:0]    IV           = 64'h34550F14DAC02BEE,
  parameter bit                           CHECK_ALNUM  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [7:0]                msg_char,
  input  logic                      msg_last,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      digest_valid,
  output logic                      err_invalid_char
);

  localparam int unsigned W          = 8 * DIGEST_BYTES;
  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {StIdle, StAcc, StRnd, StDone} state_e;

  // Byte i lives at bits [8*(N-1-i) +: 8] so that H[0] is the MSB byte.
  function automatic logic [W-1:0] round_fn(input logic [W-1:0] h, input logic [7:0] m,
                                            input logic [3:0] r);
    logic [W-1:0] res;
    logic [7:0]   cur;
    logic [7:0]   src;
    res = '0;
    for (int unsigned i = 0; i < DIGEST_BYTES; i++) begin
      cur = h[8*(DIGEST_BYTES-1-i) +: 8];
      src = h[8*(DIGEST_BYTES-1-((i+2) % DIGEST_BYTES)) +: 8];
      res[8*(DIGEST_BYTES-1-i) +: 8] = {cur[6:0], cur[7]} ^ SBOX[src ^ m ^ {4'h0, r}];
    end
    return res;
  endfunction

  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h5a)) ||
           ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] h_q, h_d;
  logic [7:0]   m_q, m_d;
  logic [3:0]   r_q, r_d;
  logic         open_q, open_d;
  logic         dv_q, dv_d;
  logic         err_q, err_d;

  logic         fresh;
  logic         accept;
  logic         reject;
  logic [W-1:0] rnd_h;
  logic [7:0]   rnd_m;
  logic [3:0]   rnd_r;
  logic [W-1:0] rnd_out;

  assign msg_ready        = (state_q != StRnd);
  assign digest           = h_q;
  assign digest_valid     = dv_q;
  assign err_invalid_char = err_q;

  assign fresh  = (state_q == StIdle) || (state_q == StDone);
  assign accept = msg_valid && msg_ready;
  assign reject = CHECK_ALNUM && !is_alnum(msg_char);

  // One shared round datapath: round 0 on accept, later rounds from the latched char.
  always_comb begin
    rnd_h = h_q;
    rnd_m = m_q;
    rnd_r = r_q;
    if (state_q != StRnd) begin
      rnd_h = fresh ? IV : h_q;
      rnd_m = msg_char;
      rnd_r = 4'd0;
    end
    rnd_out = round_fn(rnd_h, rnd_m, rnd_r);
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    r_d     = r_q;
    open_d  = open_q;
    dv_d    = dv_q;
    err_d   = 1'b0;
    if (state_q == StRnd) begin
      h_d = rnd_out;
      if (r_q == LAST_ROUND) begin
        state_d = StAcc;
        r_d     = 4'd0;
      end else begin
        r_d = r_q + 4'd1;
      end
    end else if (accept) begin
      if (msg_last) begin
        state_d = StDone;
        dv_d    = 1'b1;
        open_d  = 1'b0;
        if (fresh) h_d = IV;
      end else if (reject) begin
        err_d = 1'b1;
      end else begin
        m_d    = msg_char;
        h_d    = rnd_out;
        open_d = 1'b1;
        dv_d   = 1'b0;
        if (ROUNDS > 1) begin
          state_d = StRnd;
          r_d     = 4'd1;
        end else begin
          state_d = StAcc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= IV;
      m_q     <= 8'h00;
      r_q     <= 4'd0;
      open_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      r_q     <= r_d;
      open_q  <= open_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_light_hash_stream.sv
// Directed bench for light_hash_stream: default, single-round and unfiltered instances
// checked against a reference model that derives the S-box from GF(2^8) arithmetic.
module tb_light_hash_stream;

  localparam logic [63:0] IV_C = 64'h34550F14DAC02BEE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [3];
  logic        lst [3];
  logic [7:0]  chr [3];
  logic        rdy [3];
  logic        dv  [3];
  logic        err [3];
  logic [63:0] dig [3];

  int tests = 0;
  int fails = 0;
  bit noa_err_seen = 1'b0;

  logic [7:0] mbuf [64];
  int         mlen = 0;

  always #5 clk = ~clk;

  light_hash_stream u_def (
    .clk(clk), .rst_n(rst_n), .msg_valid(vld[0]), .msg_ready(rdy[0]), .msg_char(chr[0]),
    .msg_last(lst[0]), .digest(dig[0]), .digest_valid(dv[0]), .err_invalid_char(err[0])
  );

  light_hash_stream #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .msg_valid(vld[1]), .msg_ready(rdy[1]), .msg_char(chr[1]),
    .msg_last(lst[1]), .digest(dig[1]), .digest_valid(dv[1]), .err_invalid_char(err[1])
  );

  light_hash_stream #(.CHECK_ALNUM(1'b0)) u_noa (
    .clk(clk), .rst_n(rst_n), .msg_valid(vld[2]), .msg_ready(rdy[2]), .msg_char(chr[2]),
    .msg_last(lst[2]), .digest(dig[2]), .digest_valid(dv[2]), .err_invalid_char(err[2])
  );

  always @(negedge clk) if (rst_n && err[2]) noa_err_seen <= 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    int         e = 254;
    if (x == 8'h00) inv = 8'h00;
    else begin
      while (e != 0) begin
        if (e % 2 == 1) inv = gmul(inv, base);
        base = gmul(base, base);
        e = e / 2;
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic bit alnum(input logic [7:0] c);
    return (c inside {[8'h30:8'h39], [8'h41:8'h5a], [8'h61:8'h7a]});
  endfunction

  function automatic logic [63:0] model(input int rounds, input bit filt);
    logic [7:0]  h  [8];
    logic [7:0]  nh [8];
    logic [63:0] res;
    for (int i = 0; i < 8; i++) h[i] = IV_C[63-8*i -: 8];
    for (int c = 0; c < mlen; c++) begin
      if (!(filt && !alnum(mbuf[c]))) begin
        for (int r = 0; r < rounds; r++) begin
          for (int i = 0; i < 8; i++)
            nh[i] = rotl(h[i], 1) ^ sbox(h[(i + 2) % 8] ^ mbuf[c] ^ 8'(r));
          for (int i = 0; i < 8; i++) h[i] = nh[i];
        end
      end
    end
    for (int i = 0; i < 8; i++) res[63-8*i -: 8] = h[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    mlen = s.len();
    for (int i = 0; i < mlen; i++) mbuf[i] = s[i];
  endtask

  // Holds the beat until accepted; returns 1 ns after the accepting edge.
  task automatic beat(input int k, input logic [7:0] c, input logic l, output int waits);
    waits = 0;
    vld[k] = 1'b1;
    chr[k] = c;
    lst[k] = l;
    while (!rdy[k] && waits < 40) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 40) chk("ready_timeout", 64'(rdy[k]), 64'd1);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  task automatic send_msg(input int k, input bit check_lows);
    int w;
    int lows;
    for (int i = 0; i < mlen; i++) begin
      beat(k, mbuf[i], 1'b0, w);
      if (check_lows) begin
        lows = 0;
        while (!rdy[k] && lows < 20) begin
          lows++;
          @(posedge clk);
          #1;
        end
        chk("ready_low_cycles", 64'(lows), 64'd3);
      end
    end
  endtask

  initial begin
    int          w;
    logic [63:0] exp_az;
    logic [63:0] exp_f;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      lst[k] = 1'b0;
      chr[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_digest", dig[k], IV_C);
      chk("rst_digest_valid", 64'(dv[k]), 64'd0);
      chk("rst_ready", 64'(rdy[k]), 64'd1);
      chk("rst_err", 64'(err[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty message from IDLE
    beat(0, 8'h00, 1'b1, w);
    chk("empty_valid", 64'(dv[0]), 64'd1);
    chk("empty_digest", dig[0], IV_C);

    // Single round: H[0] = rotl(34)=68 ^ SBOX(0F^61=6E)=9F -> F7
    beat(1, 8'h61, 1'b0, w);
    chk("r1_h0", 64'(dig[1][63:56]), 64'hF7);
    load("a");
    chk("r1_digest_a", dig[1], model(1, 1'b1));
    chk("r1_ready", 64'(rdy[1]), 64'd1);
    chk("r1_valid_low", 64'(dv[1]), 64'd0);
    load("abcd");
    for (int i = 1; i < 4; i++) beat(1, mbuf[i], 1'b0, w);
    beat(1, 8'h00, 1'b1, w);
    chk("r1_valid", 64'(dv[1]), 64'd1);
    chk("r1_digest_abcd", dig[1], model(1, 1'b1));

    // Alphabet on the default instance, repeated, then with a changed last char
    load("abcdefghijklmnopqrstuvwxyz");
    exp_az = model(4, 1'b1);
    send_msg(0, 1'b1);
    beat(0, 8'h00, 1'b1, w);
    chk("az_valid", 64'(dv[0]), 64'd1);
    chk("az_digest", dig[0], exp_az);
    send_msg(0, 1'b0);
    beat(0, 8'h00, 1'b1, w);
    chk("az_repeat", dig[0], exp_az);
    beat(0, 8'h00, 1'b1, w);
    chk("done_term_iv", dig[0], IV_C);
    chk("done_term_valid", 64'(dv[0]), 64'd1);
    mbuf[25] = 8'h5a;
    send_msg(0, 1'b0);
    beat(0, 8'h00, 1'b1, w);
    chk("az_changed", dig[0], model(4, 1'b1));
    tests++;
    assert (dig[0] !== exp_az) else begin
      fails++;
      $error("FAIL az_differs: observed %h required not %h", dig[0], exp_az);
    end

    // Filtering: FF and space rejected back to back
    load("abcde");
    exp_f = model(4, 1'b1);
    load("abc");
    send_msg(0, 1'b0);
    beat(0, 8'hFF, 1'b0, w);
    chk("rej_ff_pulse", 64'(err[0]), 64'd1);
    beat(0, 8'h20, 1'b0, w);
    chk("rej_sp_pulse", 64'(err[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("rej_pulse_end", 64'(err[0]), 64'd0);
    beat(0, 8'h64, 1'b0, w);
    beat(0, 8'h65, 1'b0, w);
    beat(0, 8'h00, 1'b1, w);
    chk("filter_digest", dig[0], exp_f);
    load("abc");
    mbuf[3] = 8'hFF;
    mbuf[4] = 8'h20;
    mbuf[5] = 8'h64;
    mbuf[6] = 8'h65;
    mlen = 7;
    send_msg(2, 1'b0);
    beat(2, 8'h00, 1'b1, w);
    chk("noalnum_digest", dig[2], model(4, 1'b0));
    chk("noalnum_err", 64'(noa_err_seen), 64'd0);

    // Reset in the middle of the rounds
    beat(0, 8'h71, 1'b0, w);
    chk("midrnd_busy", 64'(rdy[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrnd_rst_ready", 64'(rdy[0]), 64'd1);
    chk("midrnd_rst_digest", dig[0], IV_C);
    chk("midrnd_rst_valid", 64'(dv[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load("abc");
    send_msg(0, 1'b0);
    beat(0, 8'h00, 1'b1, w);
    chk("after_rst_digest", dig[0], model(4, 1'b1));

    // Beat held valid through RND is taken exactly once
    beat(0, 8'h78, 1'b0, w);
    beat(0, 8'h79, 1'b0, w);
    chk("hold_stalls", 64'(w), 64'd3);
    beat(0, 8'h00, 1'b1, w);
    load("xy");
    chk("hold_digest", dig[0], model(4, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
